// File: rtl/doppler_mix_pkg.sv
// Shared widths, epoch state type and saturation helper for the Doppler mixer.
package doppler_mix_pkg;

  localparam int NCO_W  = 6;
  localparam int GAIN_W = 8;
  localparam int PROD_W = 15;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } epoch_state_t;

  // Clamp a signed value into the range of a signed word of 'width' bits.
  function automatic logic signed [63:0] sat_to(input int width, input logic signed [63:0] value);
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (width - 1));
    if (value > max_v) begin
      return max_v;
    end else if (value < min_v) begin
      return min_v;
    end
    return value;
  endfunction

endpackage

// File: rtl/mix_lane.sv
// One mixer component: chip sign, gain scale, epoch accumulate and saturate.
module mix_lane
  import doppler_mix_pkg::*;
#(
  parameter int ACC_W = 19,
  parameter int OUT_W = 16,
  parameter int SHIFT = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_en0,
  input  logic              i_chip,
  input  logic [GAIN_W-1:0] i_gain,
  input  logic [NCO_W-1:0]  i_x,
  input  logic              i_en1,
  input  logic              i_en2,
  input  logic              i_first2,
  input  logic              i_last2,
  output logic [OUT_W-1:0]  o_y,
  output logic              o_sat
);

  localparam int MUL_W = PROD_W + 1;

  logic signed [NCO_W:0]   w_x_ext;
  logic signed [NCO_W:0]   w_x1;
  logic signed [NCO_W:0]   r_x1;
  logic [GAIN_W-1:0]       r_gain1;
  logic signed [MUL_W-1:0] w_mul_a;
  logic signed [MUL_W-1:0] w_mul_b;
  logic signed [MUL_W-1:0] w_prod;
  logic signed [PROD_W-1:0] r_p;
  logic signed [ACC_W-1:0] w_p_ext;
  logic signed [ACC_W-1:0] w_acc_next;
  logic signed [ACC_W-1:0] r_acc;
  logic signed [ACC_W-1:0] w_shifted;
  logic signed [63:0]      w_wide;
  logic signed [63:0]      w_sat_wide;
  logic                    w_clip;
  logic [OUT_W-1:0]        r_y;
  logic                    r_sat;

  // One extra bit keeps -(-32) = +32 exact.
  assign w_x_ext = $signed({i_x[NCO_W-1], i_x});
  assign w_x1    = i_chip ? -w_x_ext : w_x_ext;

  assign w_mul_a = $signed({{(MUL_W-NCO_W-1){r_x1[NCO_W]}}, r_x1});
  assign w_mul_b = $signed({{(MUL_W-GAIN_W){1'b0}}, r_gain1});
  assign w_prod  = w_mul_a * w_mul_b;

  assign w_p_ext    = $signed({{(ACC_W-PROD_W){r_p[PROD_W-1]}}, r_p});
  assign w_acc_next = i_first2 ? w_p_ext : r_acc + w_p_ext;
  assign w_shifted  = w_acc_next >>> SHIFT;
  assign w_wide     = $signed({{(64-ACC_W){w_shifted[ACC_W-1]}}, w_shifted});
  assign w_sat_wide = sat_to(OUT_W, w_wide);
  assign w_clip     = (w_sat_wide != w_wide);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_x1    <= '0;
      r_gain1 <= '0;
      r_p     <= '0;
      r_acc   <= '0;
      r_y     <= '0;
      r_sat   <= 1'b0;
    end else begin
      if (i_en0) begin
        r_x1    <= w_x1;
        r_gain1 <= i_gain;
      end
      if (i_en1) begin
        r_p <= w_prod[PROD_W-1:0];
      end
      if (i_en2) begin
        r_acc <= w_acc_next;
      end
      if (i_en2 && i_last2) begin
        r_y   <= w_sat_wide[OUT_W-1:0];
        r_sat <= w_clip;
      end
    end
  end

  assign o_y   = r_y;
  assign o_sat = r_sat;

endmodule

// File: rtl/doppler_mixer.sv
// Sums per-channel chip/gain-weighted NCO samples over an epoch into one
// saturated complex baseband sample; owns framing, beat counting and flags.
module doppler_mixer
  import doppler_mix_pkg::*;
#(
  parameter int MAX_CH = 16,
  parameter int OUT_W  = 16,
  parameter int SHIFT  = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dv_in,
  input  logic              first_in,
  input  logic              last_in,
  input  logic              chip_in,
  input  logic [GAIN_W-1:0] gain_in,
  input  logic [NCO_W-1:0]  real_in,
  input  logic [NCO_W-1:0]  imag_in,
  output logic              dv_out,
  output logic [OUT_W-1:0]  real_out,
  output logic [OUT_W-1:0]  imag_out,
  output logic              sat_flag,
  output logic              frame_err
);

  localparam int ACC_W = PROD_W + $clog2(MAX_CH);
  localparam int CNT_W = $clog2(MAX_CH + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_CH);

  epoch_state_t     r_state;
  epoch_state_t     w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_accept;
  logic             w_ferr;

  logic r_v1, r_first1, r_last1;
  logic r_v2, r_first2, r_last2;
  logic r_v3;

  logic [NCO_W-1:0] w_x   [2];
  logic [OUT_W-1:0] w_y   [2];
  logic             w_sat [2];

  assign w_x[0] = real_in;
  assign w_x[1] = imag_in;

  // Framing is resolved at the input: only beats that belong to a legal
  // epoch enter the pipeline, so downstream stages never see a stray beat.
  // An epoch longer than MAX_CH is aborted before the accumulator can grow.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_accept     = 1'b0;
    w_ferr       = 1'b0;
    if (dv_in) begin
      if (first_in) begin
        w_accept = 1'b1;
        w_ferr   = (r_state == ACCUM);
        if (last_in) begin
          w_state_next = IDLE;
          w_cnt_next   = '0;
        end else begin
          w_state_next = ACCUM;
          w_cnt_next   = CNT_W'(1);
        end
      end else if (r_state == IDLE) begin
        w_ferr = 1'b1;
      end else if (r_cnt == MAX_CNT) begin
        w_ferr       = 1'b1;
        w_state_next = IDLE;
        w_cnt_next   = '0;
      end else begin
        w_accept = 1'b1;
        if (last_in) begin
          w_state_next = IDLE;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      frame_err <= 1'b0;
      r_v1      <= 1'b0;
      r_first1  <= 1'b0;
      r_last1   <= 1'b0;
      r_v2      <= 1'b0;
      r_first2  <= 1'b0;
      r_last2   <= 1'b0;
      r_v3      <= 1'b0;
      dv_out    <= 1'b0;
      real_out  <= '0;
      imag_out  <= '0;
      sat_flag  <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      frame_err <= frame_err | w_ferr;
      r_v1      <= w_accept;
      if (w_accept) begin
        r_first1 <= first_in;
        r_last1  <= last_in;
      end
      r_v2 <= r_v1;
      if (r_v1) begin
        r_first2 <= r_first1;
        r_last2  <= r_last1;
      end
      r_v3   <= r_v2 & r_last2;
      dv_out <= r_v3;
      if (r_v3) begin
        real_out <= w_y[0];
        imag_out <= w_y[1];
      end
      sat_flag <= sat_flag | (r_v3 & (w_sat[0] | w_sat[1]));
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    mix_lane #(
      .ACC_W (ACC_W),
      .OUT_W (OUT_W),
      .SHIFT (SHIFT)
    ) u_lane (
      .clk      (clk),
      .reset    (reset),
      .i_en0    (w_accept),
      .i_chip   (chip_in),
      .i_gain   (gain_in),
      .i_x      (w_x[gi]),
      .i_en1    (r_v1),
      .i_en2    (r_v2),
      .i_first2 (r_first2),
      .i_last2  (r_last2),
      .o_y      (w_y[gi]),
      .o_sat    (w_sat[gi])
    );
  end

endmodule

// File: doc/doppler_mixer.md
# doppler_mixer

Sits directly downstream of `doppler_nco` in the GPS synthesizer. For each satellite channel it multiplies the NCO's complex carrier sample by the channel's spread code chip (±1) and its 8-bit amplitude gain. Channels arrive time-multiplexed as one beat per channel, and the block sums all channels of an epoch into one saturated complex baseband sample for the DAC/up-converter path.

## Interface
Parameters:
- `MAX_CH`, 16: maximum channels per epoch; sets the accumulator growth.
- `OUT_W`, 16: output sample width (signed).
- `SHIFT`, 0: arithmetic right shift applied to the epoch sum before saturation.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `dv_in`  in  1  beat valid, aligned with `doppler_nco` `dv_out`.
- `first_in`  in  1  beat is channel 0 of an epoch; qualified by `dv_in`.
- `last_in`  in  1  beat is the final channel of an epoch; qualified by `dv_in`.
- `chip_in`  in  1  code XOR nav-data bit: 0 means +1, 1 means −1.
- `gain_in`  in  8  unsigned channel amplitude.
- `real_in`  in  6  signed NCO cosine sample.
- `imag_in`  in  6  signed NCO sine sample.
- `dv_out`  out  1  one-cycle pulse when an epoch sum is valid.
- `real_out`  out  OUT_W  signed I sum.
- `imag_out`  out  OUT_W  signed Q sum.
- `sat_flag`  out  1  sticky; set when any output saturated.
- `frame_err`  out  1  sticky; set on a framing violation.

## Operation
- Two identical lanes (I, Q), each a 3-stage pipeline. All stages advance only on beats carrying valid; `first`/`last` travel with the data.
- S1, sign: `x1 = chip ? −x : x`, 7-bit signed, so −(−32) = +32 is exact.
- S2, scale: `p = x1 * gain`, 15-bit signed; range −8160..+8160.
- S3, accumulate: if `first`, `acc = p`; else `acc = acc + p`. The accumulator is 15 + clog2(MAX_CH) bits and never wraps for ≤ MAX_CH beats.
- On a `last` beat in S3:
  - `y = (acc_next >>> SHIFT)`, saturated to [−2^(OUT_W−1), 2^(OUT_W−1)−1].
  - The result is registered to `real_out`/`imag_out` and `dv_out` pulses.
  - If either lane clipped, `sat_flag` is set.
- Beat counter: cleared by `first`, incremented per beat, reset to idle after `last`.
- State machine per epoch: IDLE → ACCUM on `first`; ACCUM → IDLE on `last`; `first` and `last` on the same beat completes a one-channel epoch and the state stays IDLE.
- Framing violations set `frame_err`:
  - Beat without `first` while IDLE: the beat is dropped, with no accumulation and no output.
  - `first` while in ACCUM: the partial sum is discarded and the epoch restarts from this beat.
  - Beat count exceeds MAX_CH without `last`: the epoch is aborted, state goes to IDLE, and no output is produced.
- `real_out`/`imag_out` hold their value between `dv_out` pulses.

## Timing
- Reset values: `dv_out` = 0, `real_out` = 0, `imag_out` = 0, `sat_flag` = 0, `frame_err` = 0. Pipeline valids, accumulator and state machine go to IDLE/0.
- Latency: a `last` beat accepted at edge n produces `dv_out` high for the cycle following edge n+3.
- Throughput: one beat per clock with no back-pressure. Gaps in `dv_in` are allowed anywhere, including mid-epoch, and are invisible in the result.
- Reset asserted mid-epoch or with results in flight: all in-flight data is discarded and no `dv_out` follows deassertion.
- Sticky flags clear only on reset.

## Structure
- Package `doppler_mix_pkg`:
  - Constants `NCO_W` = 6, `GAIN_W` = 8, `PROD_W` = 15.
  - Function `sat_to(width, value)`.
  - Epoch state enum {IDLE, ACCUM}.
- Sub-module `mix_lane`: S1–S3 datapath plus saturation for one component, instantiated twice (I, Q).
- The top level owns the valid/first/last pipeline, state machine, beat counter and sticky flags, and reports per-lane `sat` into `sat_flag`.

## Test plan
- One-channel epoch (`first` = `last` = 1), chip = 0, gain = 1, real = 5, imag = −3 → `dv_out` after 3 cycles; `real_out` = 5, `imag_out` = −3; flags 0.
- chip = 1, gain = 255, real = −32, imag = 31 → `real_out` = 8160, `imag_out` = −7905.
- 4-channel epoch with a 2-cycle `dv_in` gap after beat 2; each beat gain = 100, real = 31, imag = 0, chip = 0 → single `dv_out`, `real_out` = 12400, `imag_out` = 0.
- OUT_W = 12: 2-channel epoch, each chip = 1, real = −32, gain = 255 → `real_out` = 2047, `sat_flag` = 1 and stays 1.
- `first` arrives on beat 3 of an open epoch, then a new 2-beat epoch with real = 1, gain = 1 → `frame_err` = 1, output = 2, exactly one `dv_out`. Also: MAX_CH + 1 beats with no `last` → `frame_err` = 1 and no `dv_out`.
- `reset` low for 1 cycle between the `last` beat and its `dv_out` → no `dv_out`; all outputs 0.
